pipe_hazard_controller: RTL and testbench

- Sequencing controller for the 5-stage pipeline.
- Drives enable/clear of the IF/ID, ID/EX, EX/ME and ME/WB registers, plus PC write-enable and PC-source select.
- Resolves load-use stalls, taken-branch flushes, memory wait states, interrupt entry/return and halt.
- Keeps a saturating stall-cycle counter for the debug display.

---
 rtl/pipe_hazard_controller_pkg.sv | 19 +
 rtl/pipe_hazard_controller_hazard_detect.sv | 20 ++
 rtl/pipe_hazard_controller.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_controller.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_controller_pkg.sv
// Shared encodings for the pipeline sequencing controller: PC-source selects,
// controller state encoding and the default interrupt vector.
package pipe_hazard_controller_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_VEC = 2'd2;
    localparam logic [1:0] PCSEL_EPC = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEMWAIT  = 2'd1,
        ST_INTENTER = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_VECTOR_ADDR = 32'h0000_0800;

endpackage

// File: rtl/pipe_hazard_controller_hazard_detect.sv
// Combinational load-use comparator: flags when the load in EX writes a
// register that the instruction in ID is about to read.
module pipe_hazard_controller_hazard_detect (
    input  logic       i_exMemRead,
    input  logic [4:0] i_exRt,
    input  logic [4:0] i_idRs,
    input  logic [4:0] i_idRt,
    input  logic       i_idUsesRt,
    output logic       o_loadUse
);

    logic w_rsHit;
    logic w_rtHit;

    // $0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign w_rsHit   = (i_exRt == i_idRs);
    assign w_rtHit   = i_idUsesRt && (i_exRt == i_idRt);
    assign o_loadUse = i_exMemRead && (i_exRt != 5'd0) && (w_rsHit || w_rtHit);

endmodule

// File: rtl/pipe_hazard_controller.sv
// Sequencing controller for the 5-stage pipeline: stalls, flushes, memory
// waits, interrupt entry/return and halt, plus a saturating stall counter.
module pipe_hazard_controller
    import pipe_hazard_controller_pkg::*;
#(
    parameter logic [31:0] VECTOR_ADDR = DEFAULT_VECTOR_ADDR,
    parameter int          CNT_W       = 32
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [4:0]       idRs,
    input  logic [4:0]       idRt,
    input  logic             idUsesRt,
    input  logic             idEret,
    input  logic             idValid,
    input  logic [31:0]      idPc,
    input  logic [31:0]      ifPc,
    input  logic             exMemRead,
    input  logic [4:0]       exRt,
    input  logic             exBranchTaken,
    input  logic             memBusy,
    input  logic             irq,
    input  logic             wbHalt,
    input  logic             go,
    output logic             pcEn,
    output logic [1:0]       pcSel,
    output logic             ifidEn,
    output logic             ifidClr,
    output logic             idexEn,
    output logic             idexClr,
    output logic             exmeEn,
    output logic             exmeClr,
    output logic             mewbEn,
    output logic             mewbClr,
    output logic             epcLoad,
    output logic [31:0]      epcValue,
    output logic             intAck,
    output logic             halted,
    output logic [CNT_W-1:0] stallCount,
    output logic [1:0]       dbgState
);

    state_t           r_state;
    state_t           w_next;
    logic             r_inService;
    logic             r_irqPend;
    logic [CNT_W-1:0] r_stallCount;
    logic             w_loadUse;
    logic             w_enterInt;
    logic             w_eret;

    pipe_hazard_controller_hazard_detect u_hazard_detect (
        .i_exMemRead (exMemRead),
        .i_exRt      (exRt),
        .i_idRs      (idRs),
        .i_idRt      (idRt),
        .i_idUsesRt  (idUsesRt),
        .o_loadUse   (w_loadUse)
    );

    // MEMWAIT shares the RUN rules: while memBusy holds it re-selects MEMWAIT,
    // and the cycle memBusy drops is resolved like RUN with no extra latency.
    always_comb begin
        w_next     = r_state;
        pcEn       = 1'b1;
        pcSel      = PCSEL_SEQ;
        ifidEn     = 1'b1;
        ifidClr    = 1'b0;
        idexEn     = 1'b1;
        idexClr    = 1'b0;
        exmeEn     = 1'b1;
        exmeClr    = 1'b0;
        mewbEn     = 1'b1;
        mewbClr    = 1'b0;
        epcLoad    = 1'b0;
        epcValue   = idValid ? idPc : ifPc;
        w_enterInt = 1'b0;
        w_eret     = 1'b0;
        case (r_state)
            ST_RUN, ST_MEMWAIT: begin
                w_next = ST_RUN;
                if (memBusy) begin
                    ifidEn  = 1'b0;
                    idexEn  = 1'b0;
                    exmeEn  = 1'b0;
                    mewbClr = 1'b1;
                    pcEn    = 1'b0;
                    w_next  = ST_MEMWAIT;
                end else if (wbHalt) begin
                    ifidEn = 1'b0;
                    idexEn = 1'b0;
                    exmeEn = 1'b0;
                    mewbEn = 1'b0;
                    pcEn   = 1'b0;
                    w_next = ST_HALT;
                end else if (r_irqPend && !exBranchTaken) begin
                    ifidClr    = 1'b1;
                    idexClr    = 1'b1;
                    pcEn       = 1'b0;
                    epcLoad    = 1'b1;
                    w_enterInt = 1'b1;
                    w_next     = ST_INTENTER;
                end else if (exBranchTaken) begin
                    pcSel   = PCSEL_BR;
                    ifidClr = 1'b1;
                    idexClr = 1'b1;
                end else if (idEret) begin
                    pcSel   = PCSEL_EPC;
                    ifidClr = 1'b1;
                    w_eret  = 1'b1;
                end else if (w_loadUse) begin
                    pcEn    = 1'b0;
                    ifidEn  = 1'b0;
                    idexClr = 1'b1;
                end
            end
            ST_INTENTER: begin
                pcSel   = PCSEL_VEC;
                ifidClr = 1'b1;
                w_next  = ST_RUN;
            end
            ST_HALT: begin
                ifidEn = 1'b0;
                idexEn = 1'b0;
                exmeEn = 1'b0;
                mewbEn = 1'b0;
                pcEn   = 1'b0;
                if (go) begin
                    w_next = ST_RUN;
                end
            end
            default: w_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state      <= ST_RUN;
            r_inService  <= 1'b0;
            r_irqPend    <= 1'b0;
            r_stallCount <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_INTENTER) begin
                r_inService <= 1'b1;
            end else if (w_eret) begin
                r_inService <= 1'b0;
            end
            // The INTENTER cycle itself is the entry, so a still-high level
            // there must not re-arm the request.
            if (w_enterInt) begin
                r_irqPend <= 1'b0;
            end else if (irq && !r_inService && (r_state != ST_INTENTER)) begin
                r_irqPend <= 1'b1;
            end
            if (!pcEn && (r_stallCount != {CNT_W{1'b1}})) begin
                r_stallCount <= r_stallCount + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stallCount = r_stallCount;
    assign intAck     = (r_state == ST_INTENTER);
    assign halted     = (r_state == ST_HALT);
    assign dbgState   = r_state;

    // The vector address is consumed by the PC mux via pcSel; it is kept here
    // so the vector stays a property of this controller instance.
    logic [31:0] w_vectorAddr;
    assign w_vectorAddr = VECTOR_ADDR;
    logic w_unusedVec;
    assign w_unusedVec = ^w_vectorAddr;

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Directed test of the pipeline sequencing controller: each task drives one
// scenario and compares control outputs against hand-computed vectors.
module tb_pipe_hazard_controller;

    import pipe_hazard_controller_pkg::*;

    // Control vector layout: {pcEn, pcSel[1:0], ifidEn, ifidClr, idexEn,
    // idexClr, exmeEn, exmeClr, mewbEn, mewbClr, epcLoad}
    localparam logic [12:0] C_NORMAL  = 13'b1_00_10_10_10_10_0;
    localparam logic [12:0] C_LOADUSE = 13'b0_00_00_11_10_10_0;
    localparam logic [12:0] C_BRANCH  = 13'b1_01_11_11_10_10_0;
    localparam logic [12:0] C_MEMBUSY = 13'b0_00_00_00_00_11_0;
    localparam logic [12:0] C_HALT    = 13'b0_00_00_00_00_00_0;
    localparam logic [12:0] C_IRQ     = 13'b0_00_11_11_10_10_1;
    localparam logic [12:0] C_INTENT  = 13'b1_10_11_10_10_10_0;
    localparam logic [12:0] C_ERET    = 13'b1_11_11_10_10_10_0;

    logic        clock = 1'b0;
    logic        resetN;
    logic [4:0]  idRs, idRt, exRt;
    logic        idUsesRt, idEret, idValid, exMemRead, exBranchTaken;
    logic        memBusy, irq, wbHalt, go;
    logic [31:0] idPc, ifPc;
    logic        pcEn, ifidEn, ifidClr, idexEn, idexClr, exmeEn, exmeClr;
    logic        mewbEn, mewbClr, epcLoad, intAck, halted;
    logic [1:0]  pcSel, dbgState;
    logic [31:0] epcValue;
    logic [3:0]  stallCount;
    logic [12:0] ctrl;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  exp_stall;

    always #5 clock = ~clock;

    pipe_hazard_controller #(.VECTOR_ADDR(32'h0000_0800), .CNT_W(4)) dut (
        .clock(clock), .resetN(resetN), .idRs(idRs), .idRt(idRt),
        .idUsesRt(idUsesRt), .idEret(idEret), .idValid(idValid),
        .idPc(idPc), .ifPc(ifPc), .exMemRead(exMemRead), .exRt(exRt),
        .exBranchTaken(exBranchTaken), .memBusy(memBusy), .irq(irq),
        .wbHalt(wbHalt), .go(go), .pcEn(pcEn), .pcSel(pcSel),
        .ifidEn(ifidEn), .ifidClr(ifidClr), .idexEn(idexEn),
        .idexClr(idexClr), .exmeEn(exmeEn), .exmeClr(exmeClr),
        .mewbEn(mewbEn), .mewbClr(mewbClr), .epcLoad(epcLoad),
        .epcValue(epcValue), .intAck(intAck), .halted(halted),
        .stallCount(stallCount), .dbgState(dbgState)
    );

    assign ctrl = {pcEn, pcSel, ifidEn, ifidClr, idexEn, idexClr,
                   exmeEn, exmeClr, mewbEn, mewbClr, epcLoad};

    task automatic drive_idle();
        idRs = 5'd0; idRt = 5'd0; exRt = 5'd0;
        idUsesRt = 1'b0; idEret = 1'b0; idValid = 1'b0;
        exMemRead = 1'b0; exBranchTaken = 1'b0;
        memBusy = 1'b0; irq = 1'b0; wbHalt = 1'b0; go = 1'b0;
        idPc = 32'h0; ifPc = 32'h0;
    endtask

    // Reference stall counter: one step per cycle whose expected pcEn is 0.
    task automatic stall_model(input logic [12:0] exp_ctrl);
        if (!exp_ctrl[12] && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
    endtask

    task automatic test_reset();
        @(negedge clock); #1;
        n_cmp++; if (ctrl !== C_NORMAL) begin n_err++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_NORMAL); end
        n_cmp++; if ({stallCount, halted, intAck} !== 6'b0) begin n_err++; $display("FAIL reset_regs: got %b want %b", {stallCount, halted, intAck}, 6'b0); end
        n_cmp++; if (dbgState !== ST_RUN) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbgState, ST_RUN); end
        @(negedge clock); resetN = 1'b1;
        exp_stall = 4'd0;
    endtask

    task automatic test_load_use();
        // lw $5 in EX, ID reads rs=$5
        @(negedge clock); drive_idle(); exMemRead = 1'b1; exRt = 5'd5; idRs = 5'd5; idValid = 1'b1; #1;
        n_cmp++; if (ctrl !== C_LOADUSE) begin n_err++; $display("FAIL lu_rs: got %b want %b", ctrl, C_LOADUSE); end
        n_cmp++; if (stallCount !== 4'd0) begin n_err++; $display("FAIL lu_cnt0: got %0d want 0", stallCount); end
        stall_model(C_LOADUSE);
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (ctrl !== C_NORMAL) begin n_err++; $display("FAIL lu_one_bubble: got %b want %b", ctrl, C_NORMAL); end
        n_cmp++; if (stallCount !== 4'd1) begin n_err++; $display("FAIL lu_cnt1: got %0d want 1", stallCount); end
        // rt match with rt in use
        @(negedge clock); drive_idle(); exMemRead = 1'b1; exRt = 5'd7; idRs = 5'd3; idRt = 5'd7; idUsesRt = 1'b1; #1;
        n_cmp++; if (ctrl !== C_LOADUSE) begin n_err++; $display("FAIL lu_rt: got %b want %b", ctrl, C_LOADUSE); end
        stall_model(C_LOADUSE);
        // rt match but rt not read
        @(negedge clock); idUsesRt = 1'b0; #1;
        n_cmp++; if (ctrl !== C_NORMAL) begin n_err++; $display("FAIL lu_rt_unused: got %b want %b", ctrl, C_NORMAL); end
        // load to $0 never stalls
        @(negedge clock); drive_idle(); exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0; #1;
        n_cmp++; if (ctrl !== C_NORMAL) begin n_err++; $display("FAIL lu_r0: got %b want %b", ctrl, C_NORMAL); end
        // match without a load
        @(negedge clock); drive_idle(); exRt = 5'd5; idRs = 5'd5; #1;
        n_cmp++; if (ctrl !== C_NORMAL) begin n_err++; $display("FAIL lu_noload: got %b want %b", ctrl, C_NORMAL); end
        n_cmp++; if (stallCount !== exp_stall) begin n_err++; $display("FAIL lu_cnt2: got %0d want %0d", stallCount, exp_stall); end
    endtask

    task automatic test_branch_over_load_use();
        @(negedge clock); drive_idle(); exBranchTaken = 1'b1; exMemRead = 1'b1; exRt = 5'd9; idRs = 5'd9; #1;
        n_cmp++; if (ctrl !== C_BRANCH) begin n_err++; $display("FAIL br_lu: got %b want %b", ctrl, C_BRANCH); end
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (stallCount !== exp_stall) begin n_err++; $display("FAIL br_nostall: got %0d want %0d", stallCount, exp_stall); end
    endtask

    task automatic test_irq();
        @(negedge clock); drive_idle(); irq = 1'b1; idValid = 1'b1; idPc = 32'h40; ifPc = 32'h44; #1;
        n_cmp++; if (ctrl !== C_NORMAL) begin n_err++; $display("FAIL irq_latch: got %b want %b", ctrl, C_NORMAL); end
        @(negedge clock); irq = 1'b0; #1;
        n_cmp++; if (ctrl !== C_IRQ) begin n_err++; $display("FAIL irq_take: got %b want %b", ctrl, C_IRQ); end
        n_cmp++; if (epcValue !== 32'h40) begin n_err++; $display("FAIL irq_epc: got %h want %h", epcValue, 32'h40); end
        stall_model(C_IRQ);
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (ctrl !== C_INTENT) begin n_err++; $display("FAIL irq_enter: got %b want %b", ctrl, C_INTENT); end
        n_cmp++; if (intAck !== 1'b1) begin n_err++; $display("FAIL irq_ack: got %b want 1", intAck); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock); drive_idle(); irq = 1'b1; #1;
            n_cmp++; if ({ctrl, intAck} !== {C_NORMAL, 1'b0}) begin n_err++; $display("FAIL irq_nested_%0d: got %b want %b", i, {ctrl, intAck}, {C_NORMAL, 1'b0}); end
        end
        @(negedge clock); drive_idle(); idEret = 1'b1; #1;
        n_cmp++; if (ctrl !== C_ERET) begin n_err++; $display("FAIL irq_eret: got %b want %b", ctrl, C_ERET); end
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (ctrl !== C_NORMAL) begin n_err++; $display("FAIL irq_after_eret: got %b want %b", ctrl, C_NORMAL); end
        n_cmp++; if (stallCount !== exp_stall) begin n_err++; $display("FAIL irq_cnt: got %0d want %0d", stallCount, exp_stall); end
    endtask

    task automatic test_irq_with_branch();
        @(negedge clock); drive_idle(); irq = 1'b1; #1;
        n_cmp++; if (ctrl !== C_NORMAL) begin n_err++; $display("FAIL irqbr_latch: got %b want %b", ctrl, C_NORMAL); end
        @(negedge clock); drive_idle(); exBranchTaken = 1'b1; #1;
        n_cmp++; if (ctrl !== C_BRANCH) begin n_err++; $display("FAIL irqbr_branch: got %b want %b", ctrl, C_BRANCH); end
        @(negedge clock); drive_idle(); idPc = 32'h40; ifPc = 32'h100; #1;
        n_cmp++; if ({ctrl, epcValue} !== {C_IRQ, 32'h100}) begin n_err++; $display("FAIL irqbr_take: got %b/%h want %b/%h", ctrl, epcValue, C_IRQ, 32'h100); end
        stall_model(C_IRQ);
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (ctrl !== C_INTENT) begin n_err++; $display("FAIL irqbr_enter: got %b want %b", ctrl, C_INTENT); end
        @(negedge clock); drive_idle(); idEret = 1'b1; #1;
        n_cmp++; if (ctrl !== C_ERET) begin n_err++; $display("FAIL irqbr_eret: got %b want %b", ctrl, C_ERET); end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); drive_idle(); memBusy = 1'b1; #1;
            n_cmp++; if (ctrl !== C_MEMBUSY) begin n_err++; $display("FAIL mem_busy_%0d: got %b want %b", i, ctrl, C_MEMBUSY); end
            if (i > 0) begin
                n_cmp++; if (dbgState !== ST_MEMWAIT) begin n_err++; $display("FAIL mem_state_%0d: got %0d want %0d", i, dbgState, ST_MEMWAIT); end
            end
            stall_model(C_MEMBUSY);
        end
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (ctrl !== C_NORMAL) begin n_err++; $display("FAIL mem_resume: got %b want %b", ctrl, C_NORMAL); end
        n_cmp++; if (stallCount !== exp_stall) begin n_err++; $display("FAIL mem_cnt: got %0d want %0d", stallCount, exp_stall); end
        @(negedge clock); drive_idle(); memBusy = 1'b1; #1;
        stall_model(C_MEMBUSY);
        @(negedge clock); drive_idle(); exBranchTaken = 1'b1; #1;
        n_cmp++; if (ctrl !== C_BRANCH) begin n_err++; $display("FAIL mem_resume_branch: got %b want %b", ctrl, C_BRANCH); end
    endtask

    task automatic test_halt();
        @(negedge clock); drive_idle(); memBusy = 1'b1; wbHalt = 1'b1; #1;
        n_cmp++; if (ctrl !== C_MEMBUSY) begin n_err++; $display("FAIL halt_memfirst: got %b want %b", ctrl, C_MEMBUSY); end
        stall_model(C_MEMBUSY);
        @(negedge clock); memBusy = 1'b0; #1;
        n_cmp++; if ({ctrl, halted} !== {C_HALT, 1'b0}) begin n_err++; $display("FAIL halt_enter: got %b want %b", {ctrl, halted}, {C_HALT, 1'b0}); end
        stall_model(C_HALT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); drive_idle(); #1;
            n_cmp++; if ({ctrl, halted} !== {C_HALT, 1'b1}) begin n_err++; $display("FAIL halt_hold_%0d: got %b want %b", i, {ctrl, halted}, {C_HALT, 1'b1}); end
            stall_model(C_HALT);
        end
        @(negedge clock); drive_idle(); go = 1'b1; #1;
        stall_model(C_HALT);
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if ({ctrl, halted} !== {C_NORMAL, 1'b0}) begin n_err++; $display("FAIL halt_go: got %b want %b", {ctrl, halted}, {C_NORMAL, 1'b0}); end
        n_cmp++; if (stallCount !== exp_stall) begin n_err++; $display("FAIL halt_cnt: got %0d want %0d", stallCount, exp_stall); end
        // irq arriving while halted is held until RUN
        @(negedge clock); drive_idle(); wbHalt = 1'b1; #1;
        @(negedge clock); drive_idle(); irq = 1'b1; #1;
        n_cmp++; if (ctrl !== C_HALT) begin n_err++; $display("FAIL halt_irq_held: got %b want %b", ctrl, C_HALT); end
        @(negedge clock); drive_idle(); go = 1'b1; #1;
        @(negedge clock); drive_idle(); ifPc = 32'h200; #1;
        n_cmp++; if ({ctrl, epcValue} !== {C_IRQ, 32'h200}) begin n_err++; $display("FAIL halt_irq_take: got %b/%h want %b/%h", ctrl, epcValue, C_IRQ, 32'h200); end
        @(negedge clock); drive_idle(); #1;
        @(negedge clock); drive_idle(); idEret = 1'b1; #1;
        n_cmp++; if (ctrl !== C_ERET) begin n_err++; $display("FAIL halt_irq_eret: got %b want %b", ctrl, C_ERET); end
    endtask

    task automatic test_reset_mid_intenter();
        @(negedge clock); drive_idle(); irq = 1'b1; #1;
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (ctrl !== C_IRQ) begin n_err++; $display("FAIL rst_irq_take: got %b want %b", ctrl, C_IRQ); end
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (intAck !== 1'b1) begin n_err++; $display("FAIL rst_in_enter: got %b want 1", intAck); end
        #1 resetN = 1'b0; #1;
        n_cmp++; if ({ctrl, intAck, halted, stallCount} !== {C_NORMAL, 2'b00, 4'd0}) begin n_err++; $display("FAIL rst_async: got %b want %b", {ctrl, intAck, halted, stallCount}, {C_NORMAL, 2'b00, 4'd0}); end
        exp_stall = 4'd0;
        @(negedge clock); resetN = 1'b1; drive_idle(); #1;
        n_cmp++; if ({ctrl, intAck} !== {C_NORMAL, 1'b0}) begin n_err++; $display("FAIL rst_irq_lost: got %b want %b", {ctrl, intAck}, {C_NORMAL, 1'b0}); end
        // inService was cleared, so a fresh irq is accepted
        @(negedge clock); drive_idle(); irq = 1'b1; #1;
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (ctrl !== C_IRQ) begin n_err++; $display("FAIL rst_irq_again: got %b want %b", ctrl, C_IRQ); end
        stall_model(C_IRQ);
        @(negedge clock); drive_idle(); #1;
        @(negedge clock); drive_idle(); idEret = 1'b1; #1;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 18; i++) begin
            @(negedge clock); drive_idle(); memBusy = 1'b1; #1;
            n_cmp++; if (stallCount !== exp_stall) begin n_err++; $display("FAIL sat_cnt_%0d: got %0d want %0d", i, stallCount, exp_stall); end
            stall_model(C_MEMBUSY);
        end
        @(negedge clock); drive_idle(); #1;
        n_cmp++; if (stallCount !== 4'hF) begin n_err++; $display("FAIL sat_hold: got %0d want 15", stallCount); end
    endtask

    initial begin
        resetN = 1'b0;
        exp_stall = 4'd0;
        drive_idle();
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_irq();
        test_irq_with_branch();
        test_mem_wait();
        test_halt();
        test_reset_mid_intenter();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
